// File: rtl/alu1_nibble_sequencer_if.sv
// Request, response and slice bundle for alu1_nibble_sequencer.
// The sequencer takes the slave view; whoever owns the requesters and the slice takes the master view.
interface alu1_nibble_sequencer_if #(parameter int WIDTH = 16);
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0][3:0]       req_ctl;
   logic [1:0][WIDTH-1:0] req_a;
   logic [1:0][WIDTH-1:0] req_b;
   logic [3:0]            slice_a;
   logic [3:0]            slice_b;
   logic [3:0]            slice_ctl;
   logic [3:0]            slice_f;
   logic [3:0]            slice_g;
   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_id;
   logic [WIDTH-1:0]      resp_f;
   logic [WIDTH-1:0]      resp_g;

   modport slave (
      input  req_valid, req_ctl, req_a, req_b, resp_ready, slice_f, slice_g,
      output req_ready, slice_a, slice_b, slice_ctl, resp_valid, resp_id, resp_f, resp_g
   );

   modport master (
      output req_valid, req_ctl, req_a, req_b, resp_ready, slice_f, slice_g,
      input  req_ready, slice_a, slice_b, slice_ctl, resp_valid, resp_id, resp_f, resp_g
   );
endinterface

// File: rtl/alu1_nibble_sequencer.sv
// Time-shares one 4-bit ALU slice between two round-robin requesters, one nibble per cycle, LSB first.
// Define ALU1_SEQ_SLICE_REG_EN to register the slice drive outputs (adds one RUN cycle of latency).
module alu1_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   alu1_nibble_sequencer_if.slave bus,
   output logic                  busy
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST_NIB = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic             last_q, last_d;
   logic             id_q, id_d;
   logic [3:0]       ctl_q, ctl_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] f_q, f_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic [WIDTH+3:0] fShift, gShift;
   logic [1:0]       reqReady;
   logic             grant;
   logic             capture;
`ifdef ALU1_SEQ_SLICE_REG_EN
   logic [3:0]       sa_q, sa_d;
   logic [3:0]       sb_q, sb_d;
   logic [3:0]       sctl_q, sctl_d;
   logic             drain_q, drain_d;
`endif

   // Round-robin: on a tie, the requester that did not win last time goes next.
   assign grant = (bus.req_valid == 2'b11) ? ~last_q : bus.req_valid[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         ctl_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         f_q     <= '0;
         g_q     <= '0;
`ifdef ALU1_SEQ_SLICE_REG_EN
         sa_q    <= '0;
         sb_q    <= '0;
         sctl_q  <= '0;
         drain_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         ctl_q   <= ctl_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         f_q     <= f_d;
         g_q     <= g_d;
`ifdef ALU1_SEQ_SLICE_REG_EN
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         sctl_q  <= sctl_d;
         drain_q <= drain_d;
`endif
      end
   end

   // Results shift in from the top, so after NIBBLES captures nibble 0 sits in bits [3:0].
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      ctl_d    = ctl_q;
      a_d      = a_q;
      b_d      = b_q;
      cnt_d    = cnt_q;
      f_d      = f_q;
      g_d      = g_q;
      reqReady = '0;
      capture  = 1'b0;
      fShift   = {bus.slice_f, f_q};
      gShift   = {bus.slice_g, g_q};
`ifdef ALU1_SEQ_SLICE_REG_EN
      sa_d     = sa_q;
      sb_d     = sb_q;
      sctl_d   = sctl_q;
      drain_d  = drain_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               reqReady[grant] = 1'b1;
               last_d  = grant;
               id_d    = grant;
               ctl_d   = bus.req_ctl[grant];
               a_d     = bus.req_a[grant];
               b_d     = bus.req_b[grant];
               cnt_d   = '0;
               f_d     = '0;
               g_d     = '0;
`ifdef ALU1_SEQ_SLICE_REG_EN
               drain_d = 1'b0;
`endif
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef ALU1_SEQ_SLICE_REG_EN
            // Issue nibble cnt into the output registers; the slice answer for it is captured next cycle.
            capture = drain_q || (cnt_q != '0);
            if (!drain_q) begin
               sa_d   = 4'(a_q >> {cnt_q, 2'b00});
               sb_d   = 4'(b_q >> {cnt_q, 2'b00});
               sctl_d = ctl_q;
               if (cnt_q == LAST_NIB) drain_d = 1'b1;
               else                   cnt_d   = cnt_q + 1'b1;
            end else begin
               state_d = DONE;
            end
`else
            capture = 1'b1;
            if (cnt_q == LAST_NIB) state_d = DONE;
            else                   cnt_d   = cnt_q + 1'b1;
`endif
            if (capture) begin
               f_d = fShift[WIDTH+3:4];
               g_d = gShift[WIDTH+3:4];
            end
         end
         DONE: begin
            if (bus.resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef ALU1_SEQ_SLICE_REG_EN
   assign bus.slice_a   = sa_q;
   assign bus.slice_b   = sb_q;
   assign bus.slice_ctl = sctl_q;
`else
   assign bus.slice_a   = 4'(a_q >> {cnt_q, 2'b00});
   assign bus.slice_b   = 4'(b_q >> {cnt_q, 2'b00});
   assign bus.slice_ctl = ctl_q;
`endif

   // Gate the accept pulse with reset so a requester held valid during reset never sees req_ready.
   assign bus.req_ready  = reqReady & {2{rst_n}};
   assign bus.resp_valid = (state_q == DONE);
   assign bus.resp_id    = id_q;
   assign bus.resp_f     = f_q;
   assign bus.resp_g     = g_q;
   assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_alu1_nibble_sequencer.sv
// Directed bench for alu1_nibble_sequencer: drives both requesters, models the 4-bit slice, checks results.
// Honours ALU1_SEQ_SLICE_REG_EN for the expected request-to-response latency.
module tb_alu1_nibble_sequencer;
   localparam int WIDTH   = 16;
   localparam int NIBBLES = WIDTH / 4;
`ifdef ALU1_SEQ_SLICE_REG_EN
   localparam int LATENCY = NIBBLES + 2;
`else
   localparam int LATENCY = NIBBLES + 1;
`endif

   typedef struct {
      int               id;
      logic [3:0]       ctl;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] expF;
      logic [WIDTH-1:0] expG;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   testsRun = 0;
   int   testsFailed = 0;
   vec_t vecs [8];

   alu1_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu1_nibble_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   // The 4-bit slice: f is the X term, g the Y term with bit 3 gated by ctl3.
   function automatic logic [7:0] sliceEval(input logic [3:0] ctl, input logic [3:0] a, input logic [3:0] b);
      logic [3:0] x, y;
      x = ~(a | (b & {4{ctl[0]}}) | (~b & {4{ctl[1]}}));
      y = ~((a & ~b & {4{ctl[2]}}) | (a & b & {4{ctl[3]}}));
      return {x, y & {ctl[3], 3'b111}};
   endfunction

   // Whole-word reference for the same slice function, independent of the nibble sequencing.
   function automatic logic [2*WIDTH-1:0] wordModel(input logic [3:0] ctl, input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
      logic [WIDTH-1:0] x, y, mask;
      x    = ~(a | (b & {WIDTH{ctl[0]}}) | (~b & {WIDTH{ctl[1]}}));
      y    = ~((a & ~b & {WIDTH{ctl[2]}}) | (a & b & {WIDTH{ctl[3]}}));
      mask = {NIBBLES{ctl[3], 3'b111}};
      return {x, y & mask};
   endfunction

   assign {bus.slice_f, bus.slice_g} = sliceEval(bus.slice_ctl, bus.slice_a, bus.slice_b);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkResetState(input string prefix);
      checkOutput({prefix, "_req_ready"},  32'(bus.req_ready),  32'd0);
      checkOutput({prefix, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      checkOutput({prefix, "_resp_id"},    32'(bus.resp_id),    32'd0);
      checkOutput({prefix, "_resp_f"},     32'(bus.resp_f),     32'd0);
      checkOutput({prefix, "_resp_g"},     32'(bus.resp_g),     32'd0);
      checkOutput({prefix, "_slice_a"},    32'(bus.slice_a),    32'd0);
      checkOutput({prefix, "_slice_b"},    32'(bus.slice_b),    32'd0);
      checkOutput({prefix, "_slice_ctl"},  32'(bus.slice_ctl),  32'd0);
      checkOutput({prefix, "_busy"},       32'(busy),           32'd0);
   endtask

   // Raise one requester's valid, wait (bounded) for its accept, then drop valid right after the grant edge.
   task automatic applyStimulus(input string name, input int id, input logic [3:0] ctl,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int waited = 0;
      bus.req_valid[id] = 1'b1;
      bus.req_ctl[id]   = ctl;
      bus.req_a[id]     = a;
      bus.req_b[id]     = b;
      #1;
      while (!bus.req_ready[id] && waited < 20) begin
         @(negedge clk);
         #1;
         waited++;
      end
      checkOutput({name, "_req_ready"}, 32'(bus.req_ready), 32'(1 << id));
      @(posedge clk);
      #1;
      bus.req_valid[id] = 1'b0;
   endtask

   // Called one step into the first RUN cycle; optionally stalls DONE before completing the handshake.
   task automatic finishOp(input string name, input int expId, input logic [WIDTH-1:0] expF,
                           input logic [WIDTH-1:0] expG, input int holdCycles);
      int lat = 1;
      bit stable = 1'b1;
      bit noGrant = 1'b1;
      while (!bus.resp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({name, "_latency"}, 32'(lat), 32'(LATENCY));
      checkOutput({name, "_resp_f"},  32'(bus.resp_f),  32'(expF));
      checkOutput({name, "_resp_g"},  32'(bus.resp_g),  32'(expG));
      checkOutput({name, "_resp_id"}, 32'(bus.resp_id), 32'(expId));
      if (holdCycles > 0) begin
         for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            if (!bus.resp_valid || bus.resp_f !== expF || bus.resp_g !== expG || bus.resp_id !== 1'(expId))
               stable = 1'b0;
            if (bus.req_ready !== 2'b00) noGrant = 1'b0;
         end
         checkOutput({name, "_hold_stable"},   32'(stable),  32'd1);
         checkOutput({name, "_hold_no_grant"}, 32'(noGrant), 32'd1);
      end
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.resp_ready = 1'b0;
      checkOutput({name, "_resp_valid_drop"}, 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int grants;
      int lowCount;
      int lastGrantCyc;
      logic [2*WIDTH-1:0] expFG;

      vecs[0] = '{0, 4'b1100, 16'h00F0, 16'hFFFF, 16'hFF0F, 16'hFF0F};
      vecs[1] = '{1, 4'b0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h7777};
      vecs[2] = '{0, 4'b0001, 16'h1234, 16'h00FF, 16'hED00, 16'h7777};
      vecs[3] = '{1, 4'b0010, 16'h1234, 16'h00FF, 16'h00CB, 16'h7777};
      vecs[4] = '{0, 4'b1000, 16'hA5A5, 16'h0F0F, 16'h5A5A, 16'hFAFA};
      vecs[5] = '{1, 4'b0100, 16'hA5A5, 16'h0F0F, 16'h5A5A, 16'h5757};
      vecs[6] = '{0, 4'b0011, 16'h0000, 16'h1234, 16'h0000, 16'h7777};
      vecs[7] = '{1, 4'b1111, 16'h0F0F, 16'h00FF, 16'h0000, 16'hF0F0};

      bus.req_valid  = 2'b00;
      bus.req_ctl    = '0;
      bus.req_a      = '0;
      bus.req_b      = '0;
      bus.resp_ready = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(negedge clk);
      checkResetState("reset");
      rst_n = 1'b1;

      // Single-requester operations from the table.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         applyStimulus($sformatf("vec%0d", i), vecs[i].id, vecs[i].ctl, vecs[i].a, vecs[i].b);
         finishOp($sformatf("vec%0d", i), vecs[i].id, vecs[i].expF, vecs[i].expG, 0);
      end

      // Both requesters held valid with resp_ready high: grants alternate, one idle cycle between ops.
      @(negedge clk);
      bus.req_ctl[0] = vecs[0].ctl; bus.req_a[0] = vecs[0].a; bus.req_b[0] = vecs[0].b;
      bus.req_ctl[1] = vecs[1].ctl; bus.req_a[1] = vecs[1].a; bus.req_b[1] = vecs[1].b;
      bus.req_valid  = 2'b11;
      bus.resp_ready = 1'b1;
      grants = 0;
      lowCount = 0;
      lastGrantCyc = 0;
      for (int cyc = 0; cyc < 100 && grants < 4; cyc++) begin
         #1;
         if (grants > 0 && !busy) lowCount++;
         if (bus.req_ready != 2'b00) begin
            checkOutput($sformatf("rr_grant%0d", grants), 32'(bus.req_ready), (grants % 2 == 0) ? 32'd1 : 32'd2);
            if (grants > 0)
               checkOutput($sformatf("rr_spacing%0d", grants), 32'(cyc - lastGrantCyc), 32'(LATENCY + 1));
            lastGrantCyc = cyc;
            grants++;
         end
         @(negedge clk);
      end
      checkOutput("rr_grant_count", 32'(grants), 32'd4);
      checkOutput("rr_busy_low_cycles", 32'(lowCount), 32'd3);
      bus.req_valid  = 2'b00;
      bus.resp_ready = 1'b0;
      finishOp("rr_last", 1, vecs[1].expF, vecs[1].expG, 0);

      // DONE stalled for 10 cycles while requester 1 waits; it is granted right after the handshake.
      @(negedge clk);
      applyStimulus("stall", 0, vecs[2].ctl, vecs[2].a, vecs[2].b);
      bus.req_valid[1] = 1'b1;
      bus.req_ctl[1]   = vecs[3].ctl;
      bus.req_a[1]     = vecs[3].a;
      bus.req_b[1]     = vecs[3].b;
      finishOp("stall", 0, vecs[2].expF, vecs[2].expG, 10);
      checkOutput("stall_next_grant", 32'(bus.req_ready), 32'd2);
      @(posedge clk);
      #1;
      bus.req_valid[1] = 1'b0;
      finishOp("stall_next", 1, vecs[3].expF, vecs[3].expG, 0);

      // Reset during RUN cycle 2 abandons the operation; the next one is clean.
      @(negedge clk);
      applyStimulus("abort", 1, vecs[5].ctl, vecs[5].a, vecs[5].b);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkResetState("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus("after_reset", 0, vecs[4].ctl, vecs[4].a, vecs[4].b);
      finishOp("after_reset", 0, vecs[4].expF, vecs[4].expG, 0);

      // Payload changed right after acceptance must not affect the result.
      @(negedge clk);
      expFG = wordModel(4'b0110, 16'h3C3C, 16'h0FF0);
      applyStimulus("late_change", 0, 4'b0110, 16'h3C3C, 16'h0FF0);
      bus.req_a[0]   = 16'hFFFF;
      bus.req_b[0]   = 16'h0000;
      bus.req_ctl[0] = 4'b0000;
      finishOp("late_change", 0, expFG[2*WIDTH-1:WIDTH], expFG[WIDTH-1:0], 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end
endmodule

// File: doc/alu1_nibble_sequencer.md
Name: alu1_nibble_sequencer

Overview:
- Controller that time-shares one combinational 4-bit ALU slice between two requesters.
- Slice inputs: a[3:0], b[3:0], ctl[3:0]. Slice outputs: f[3:0] and g[3:0].
- Each accepted request carries WIDTH-bit operands. The block streams them through the slice one nibble per cycle, LSB nibble first.
- It assembles the WIDTH-bit f and g result words and returns them on a single tagged response channel.
- It sits between the operand-fetch requesters and the shared slice instance.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived local value: slice passes per operation.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; one-hot single-cycle pulse
- req_ctl  in  2x4  per-requester slice control code (bit0..bit3 map to slice ctl0..ctl3)
- req_a  in  2xWIDTH  per-requester operand A
- req_b  in  2xWIDTH  per-requester operand B
- slice_a  out  4  nibble of A driven to the slice
- slice_b  out  4  nibble of B driven to the slice
- slice_ctl  out  4  control code driven to the slice
- slice_f  in  4  slice f outputs
- slice_g  in  4  slice g outputs
- resp_valid  out  1  result available
- resp_ready  in  1  consumer accepts result
- resp_id  out  1  index of the requester that owns the result
- resp_f  out  WIDTH  assembled f word
- resp_g  out  WIDTH  assembled g word
- busy  out  1  high in any state other than IDLE

Behaviour:
Reset:
- State IDLE; req_ready=0, resp_valid=0, resp_id=0, resp_f=0, resp_g=0, slice_a/b/ctl=0, busy=0.
- Round-robin pointer last=1, so requester 0 wins the first tie.
- Reset asserted mid-operation abandons the operation: no response is produced and the partial result is cleared.

States:
- IDLE
  - If any req_valid is set, grant one requester by round-robin: prefer ~last when both are valid.
  - Pulse req_ready[grant] for exactly this cycle.
  - Latch ctl, A, B and id into internal registers; set last=grant; clear the nibble counter and the result shift registers.
  - Go to RUN.
  - If no request is valid, stay in IDLE.
- RUN
  - In cycle k (k=0..NIBBLES-1), drive slice_a=A[4k+3:4k], slice_b=B[4k+3:4k], slice_ctl=latched ctl.
  - At the end of cycle k, capture slice_f/slice_g into bits [4k+3:4k] of resp_f/resp_g.
  - After k=NIBBLES-1, go to DONE.
  - Latency from the req_ready pulse to resp_valid is NIBBLES+1 cycles.
- DONE
  - resp_valid=1; resp_f, resp_g and resp_id are stable.
  - On resp_valid & resp_ready, drop resp_valid and go to IDLE.
  - A new grant is possible no earlier than the cycle after the handshake.

Rules:
- Requests are never accepted outside IDLE, and req_ready stays 0 there. A requester holds req_valid and its payload until it sees req_ready.
- Requester payload changes after acceptance have no effect.
- resp_ready asserted outside DONE is ignored.
- Both requesters valid continuously → grants alternate 0,1,0,1.
- A single requester valid continuously → it is granted every operation.
- slice_* are held at their last driven value outside RUN; the bench must not rely on that value.
- The nibble counter is a clog2(NIBBLES)-bit up-counter (at least 1 bit) and never wraps within an operation.
- WIDTH=4 gives a single RUN cycle.

Optional Feature:
- Macro: ALU1_SEQ_SLICE_REG_EN.
- Defined:
  - slice_a/b/ctl are registered outputs.
  - In RUN, nibble k is driven in cycle k and captured one cycle later.
  - RUN lasts NIBBLES+1 cycles, so the pipeline overlaps issue of nibble k+1 with capture of nibble k.
  - Latency is NIBBLES+2 cycles.
- Undefined: slice_* are driven combinationally from the latched operands and the counter, with latency as stated above.
- All other behaviour is identical in both builds.

Test Plan:
- Bench instantiates the real 4-bit slice combinationally, with an independent model for checking.
1. Requester 0: ctl=4'b1100, A=16'h00F0, B=16'hFFFF → one req_ready[0] pulse; resp_valid after 5 cycles (6 with macro); resp_f=16'hFF0F, resp_g=16'hFF0F, resp_id=0.
2. Requester 1: ctl=4'b0000, A=16'h0000, B=16'h0000 → resp_f=16'hFFFF, resp_g=16'h7777, resp_id=1.
3. Both requesters held valid for 4 operations, resp_ready tied high → grant order 0,1,0,1; busy low for exactly one cycle between operations.
4. resp_ready held low 10 cycles in DONE → resp_valid and data stable; no req_ready pulses; after resp_ready=1, next grant follows one cycle later.
5. rst_n pulsed low during RUN cycle 2 → all outputs at reset values immediately; next operation from requester 0 completes correctly with no stale nibbles.
6. Requester changes req_a the cycle after its req_ready pulse → result computed from the originally latched A.
